// File: rtl/dual_rail_checker.sv
// ---------------------------------------------------------------------------
// dual_rail_checker
//   Receiver for a complementary (dual-rail) signal pair. It recovers the data
//   bit from the true rail and flags pairs that are not complementary. Short
//   invalid glitches are filtered out. An invalid pair that persists for
//   FILTER sampled cycles sets a sticky fault flag and bumps a saturating
//   event counter.
//
//   Optional feature (macro DRC_SYNC_EN):
//     defined   - t_i/f_i pass through 2-flop synchronizers (reset t=0, f=1);
//                 input-to-output latency is 3 clk.
//     undefined - t_i/f_i are used directly (must be synchronous to clk);
//                 input-to-output latency is 1 clk.
//
//   Parameters:
//     FILTER    consecutive invalid sampled cycles that declare a fault (1..255)
//     CNT_W     width of err_count
//
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     t_i        true rail
//     f_i        complement rail
//     clr        synchronous clear of the sticky fault flag
//     data       recovered bit (last valid value of t)
//     valid      current sampled pair is complementary and block left IDLE
//     fault      sticky fault flag
//     both_hi    pattern of the last invalid pair: 1 = 11, 0 = 00
//     err_count  saturating count of fault events
// ---------------------------------------------------------------------------
module dual_rail_checker #(
    parameter int unsigned FILTER = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_i,
    input  logic             f_i,
    input  logic             clr,
    output logic             data,
    output logic             valid,
    output logic             fault,
    output logic             both_hi,
    output logic [CNT_W-1:0] err_count
);

    // Filter counter must hold values 0..FILTER.
    localparam int unsigned FCW  = $clog2(FILTER + 1);
    // One extra bit so the incremented count can never wrap before compare.
    localparam int unsigned FCW1 = FCW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OK      = 2'd1,
        ST_SUSPECT = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    // Sampled pair after the input stage.
    logic p_t;
    logic p_f;
    logic p_valid;

    // -----------------------------------------------------------------------
    // Input stage
    // -----------------------------------------------------------------------
`ifdef DRC_SYNC_EN
    logic [1:0] t_sync_q;
    logic [1:0] t_sync_d;
    logic [1:0] f_sync_q;
    logic [1:0] f_sync_d;

    // Shift each rail through its own two-stage synchronizer.
    always_comb begin
        t_sync_d = {t_sync_q[0], t_i};
        f_sync_d = {f_sync_q[0], f_i};
    end

    // Reset to the valid pattern (t=0, f=1) so the chain never looks invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_sync_q <= 2'b00;
            f_sync_q <= 2'b11;
        end else begin
            t_sync_q <= t_sync_d;
            f_sync_q <= f_sync_d;
        end
    end

    assign p_t = t_sync_q[1];
    assign p_f = f_sync_q[1];
`else
    assign p_t = t_i;
    assign p_f = f_i;
`endif

    assign p_valid = p_t ^ p_f;

    // -----------------------------------------------------------------------
    // Checker state and registered outputs
    // -----------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [FCW-1:0]   cnt_q;
    logic [FCW-1:0]   cnt_d;
    logic             data_q;
    logic             data_d;
    logic             valid_q;
    logic             valid_d;
    logic             fault_q;
    logic             fault_d;
    logic             both_hi_q;
    logic             both_hi_d;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] err_count_d;

    logic             enter_fault;
    logic [FCW1-1:0]  cnt_inc;

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = p_valid;
        both_hi_d   = both_hi_q;
        err_count_d = err_count_q;
        enter_fault = 1'b0;
        cnt_inc     = {1'b0, cnt_q} + FCW1'(1);

        case (state_q)
            ST_IDLE: begin
                // Invalid pairs before the first valid one are ignored.
                if (p_valid) begin
                    state_d = ST_OK;
                    data_d  = p_t;
                end
            end

            ST_OK: begin
                if (p_valid) begin
                    data_d = p_t;
                end else begin
                    both_hi_d = p_t;
                    cnt_d     = FCW'(1);
                    if (FILTER == 1) begin
                        enter_fault = 1'b1;
                    end else begin
                        state_d = ST_SUSPECT;
                    end
                end
            end

            ST_SUSPECT: begin
                if (p_valid) begin
                    // Glitch absorbed: no event recorded.
                    state_d = ST_OK;
                    cnt_d   = '0;
                    data_d  = p_t;
                end else begin
                    // A 00<->11 swap keeps counting; only a valid pair restarts.
                    both_hi_d = p_t;
                    cnt_d     = FCW'(cnt_inc);
                    if (cnt_inc == FCW1'(FILTER)) begin
                        enter_fault = 1'b1;
                    end
                end
            end

            ST_FAULT: begin
                if (p_valid) begin
                    state_d = ST_OK;
                    data_d  = p_t;
                end else begin
                    both_hi_d = p_t;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Fault entry: one event per persistent violation.
        if (enter_fault) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end

        // Entry outranks a coincident clear.
        fault_d = enter_fault | (fault_q & ~clr);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_q      <= 1'b0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            both_hi_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            both_hi_q   <= both_hi_d;
            err_count_q <= err_count_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign fault     = fault_q;
    assign both_hi   = both_hi_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_dual_rail_checker.sv
// ---------------------------------------------------------------------------
// tb_dual_rail_checker
//   Self-checking bench. Two instances share the same stimulus:
//     dut_a : FILTER=4, CNT_W=8 (default configuration)
//     dut_b : FILTER=1, CNT_W=2 (immediate faults, fast counter saturation)
//   A directed vector table checks dut_a, a hand-written sequence checks
//   dut_b saturation and clr/entry priority, and random stimulus checks both
//   against an abstract model based on invalid run lengths.
// ---------------------------------------------------------------------------
module tb_dual_rail_checker;

    logic       clk;
    logic       rst;
    logic       t_i;
    logic       f_i;
    logic       clr;

    logic       a_data, a_valid, a_fault, a_both_hi;
    logic [7:0] a_err;
    logic       b_data, b_valid, b_fault, b_both_hi;
    logic [1:0] b_err;

    int checks = 0;
    int errors = 0;

    dual_rail_checker #(.FILTER(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .t_i(t_i), .f_i(f_i), .clr(clr),
        .data(a_data), .valid(a_valid), .fault(a_fault),
        .both_hi(a_both_hi), .err_count(a_err)
    );

    dual_rail_checker #(.FILTER(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .t_i(t_i), .f_i(f_i), .clr(clr),
        .data(b_data), .valid(b_valid), .fault(b_fault),
        .both_hi(b_both_hi), .err_count(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Abstract reference: length of the current invalid run since the last
    // valid pair; a fault event happens when that run reaches FILTER.
    typedef struct {
        bit seen;
        int run;
        bit data;
        bit valid;
        bit fault;
        bit both_hi;
        int err;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mstep(mdl_t m, bit r, bit t, bit f, bit c,
                                   int filt, int maxc);
        mdl_t n;
        bit   ev;
        n  = m;
        ev = 1'b0;
        if (r) begin
            n.seen = 0; n.run = 0; n.data = 0; n.valid = 0;
            n.fault = 0; n.both_hi = 0; n.err = 0;
            return n;
        end
        n.valid = t ^ f;
        if (t ^ f) begin
            n.seen = 1;
            n.run  = 0;
            n.data = t;
        end else if (m.seen) begin
            n.both_hi = t;
            if (m.run < 1000) n.run = m.run + 1;
            ev = (n.run == filt);
        end
        if (ev && n.err < maxc) n.err = n.err + 1;
        n.fault = ev ? 1'b1 : (c ? 1'b0 : m.fault);
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, then compare both DUTs with the model.
    task automatic cycle(input bit t, input bit f, input bit c, input bit r);
        t_i = t; f_i = f; clr = c; rst = r;
        @(posedge clk);
        #1;
        ma = mstep(ma, r, t, f, c, 4, 255);
        mb = mstep(mb, r, t, f, c, 1, 3);
        check("a.data",    int'(a_data),    int'(ma.data));
        check("a.valid",   int'(a_valid),   int'(ma.valid));
        check("a.fault",   int'(a_fault),   int'(ma.fault));
        check("a.both_hi", int'(a_both_hi), int'(ma.both_hi));
        check("a.err",     int'(a_err),     ma.err);
        check("b.data",    int'(b_data),    int'(mb.data));
        check("b.valid",   int'(b_valid),   int'(mb.valid));
        check("b.fault",   int'(b_fault),   int'(mb.fault));
        check("b.both_hi", int'(b_both_hi), int'(mb.both_hi));
        check("b.err",     int'(b_err),     mb.err);
    endtask

    typedef struct {
        bit t, f, c, r;
        bit e_data, e_valid, e_fault, e_bh;
        int e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit t, bit f, bit c, bit r,
                                bit d, bit v, bit fl, bit bh, int e);
        vec_t x;
        x.t = t; x.f = f; x.c = c; x.r = r;
        x.e_data = d; x.e_valid = v; x.e_fault = fl; x.e_bh = bh; x.e_err = e;
        vecs.push_back(x);
    endfunction

    initial begin
        t_i = 0; f_i = 0; clr = 0; rst = 1;
        ma = mstep(ma, 1'b1, 0, 0, 0, 4, 255);
        mb = mstep(mb, 1'b1, 0, 0, 0, 1, 3);

        // Directed table for dut_a (FILTER=4): t f clr rst | data valid fault both_hi err
        add(0,0,0,1, 0,0,0,0,0);
        for (int i = 0; i < 10; i++) add(0,0,0,0, 0,0,0,0,0); // IDLE ignores 00
        add(1,0,0,0, 1,1,0,0,0);
        add(0,1,0,0, 0,1,0,0,0);
        add(1,0,0,0, 1,1,0,0,0);
        add(0,1,0,0, 0,1,0,0,0);
        add(1,0,0,0, 1,1,0,0,0);
        add(1,1,0,0, 1,0,0,1,0);  // glitch: 3 cycles of 11
        add(1,1,0,0, 1,0,0,1,0);
        add(1,1,0,0, 1,0,0,1,0);
        add(0,1,0,0, 0,1,0,1,0);  // absorbed, no event
        add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,1,0,1);  // 4th invalid -> fault
        add(0,0,0,0, 0,0,1,0,1);  // no further increment
        add(1,0,0,0, 1,1,1,0,1);  // fault is sticky
        add(1,0,1,0, 1,1,0,0,1);  // clr
        add(0,0,0,0, 1,0,0,0,1);
        add(1,1,0,0, 1,0,0,1,1);  // 00->11 does not restart count
        add(1,1,0,0, 1,0,0,1,1);
        add(0,0,0,0, 1,0,1,0,2);  // new event
        add(0,0,1,0, 1,0,0,0,2);  // clr while still invalid
        add(0,1,0,0, 0,1,0,0,2);
        add(1,1,0,0, 0,0,0,1,2);
        add(1,1,0,0, 0,0,0,1,2);
        add(1,1,0,0, 0,0,0,1,2);
        add(1,1,1,0, 0,0,1,1,3);  // clr coincides with entry: entry wins
        add(1,1,0,1, 0,0,0,0,0);  // reset mid-fault
        add(1,1,0,0, 0,0,0,0,0);  // IDLE after reset

        foreach (vecs[i]) begin
            cycle(vecs[i].t, vecs[i].f, vecs[i].c, vecs[i].r);
            check($sformatf("tbl%0d.data", i),  int'(a_data),    int'(vecs[i].e_data));
            check($sformatf("tbl%0d.valid", i), int'(a_valid),   int'(vecs[i].e_valid));
            check($sformatf("tbl%0d.fault", i), int'(a_fault),   int'(vecs[i].e_fault));
            check($sformatf("tbl%0d.bh", i),    int'(a_both_hi), int'(vecs[i].e_bh));
            check($sformatf("tbl%0d.err", i),   int'(a_err),     vecs[i].e_err);
        end

        // dut_b (FILTER=1, CNT_W=2): five faults saturate err_count at 3.
        cycle(0,0,0,1);
        for (int k = 1; k <= 5; k++) begin
            cycle(1,0,0,0);
            cycle(1,1,0,0);
            check($sformatf("sat%0d.err", k),   int'(b_err),   (k < 3) ? k : 3);
            check($sformatf("sat%0d.fault", k), int'(b_fault), 1);
        end
        cycle(1,0,1,0);
        check("b.clr", int'(b_fault), 0);
        cycle(0,0,1,0);
        check("b.clr_vs_entry", int'(b_fault), 1);
        check("b.err_sat_hold", int'(b_err), 3);

        // Randomized stimulus with occasional invalid bursts.
        begin
            int  burst;
            bit  bt;
            burst = 0;
            for (int n = 0; n < 4000; n++) begin
                bit t, f, c, r;
                r = ($urandom_range(0, 249) == 0);
                c = ($urandom_range(0, 9) == 0);
                if (burst == 0 && $urandom_range(0, 19) == 0) begin
                    burst = $urandom_range(2, 6);
                    bt    = 1'($urandom_range(0, 1));
                end
                if (burst > 0) begin
                    burst--;
                    t = ($urandom_range(0, 3) == 0) ? ~bt : bt;
                    f = t;
                end else begin
                    t = 1'($urandom_range(0, 1));
                    f = ($urandom_range(0, 5) == 0) ? t : ~t;
                end
                cycle(t, f, c, r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
